// File: rtl/simon_key_reader_if.sv
// Key stream from the Simon round-key reader to the round datapath.
// master drives key/index/valid; slave returns ready.
interface simon_key_reader_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 64
) ();
  logic [DATA_W-1:0] key_out;
  logic              key_valid;
  logic              key_ready;
  logic [ADDR_W-1:0] round_idx;

  modport master (output key_out, key_valid, round_idx, input key_ready);
  modport slave  (input key_out, key_valid, round_idx, output key_ready);
endinterface

// File: rtl/simon_key_reader.sv
// Read sequencer for the Simon 128/256 round-key memory: issues reads, captures the
// 1-cycle-latency data into a skid FIFO and streams keys out. Optional abort: SIMON_KEY_READER_ABORT_EN.
module simon_key_reader #(
  parameter int unsigned ROUNDS     = 72,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 decrypt_i,
`ifdef SIMON_KEY_READER_ABORT_EN
  input  logic                 abort_i,
`endif
  output logic [ADDR_W-1:0]    rd_adr_o,
  input  logic [DATA_W-1:0]    mem_dat_i,
  simon_key_reader_if.master   key_if,
  output logic                 busy_o,
  output logic                 done_o
);
  // One spare bit so a count equal to 2^ADDR_W cannot alias to zero.
  localparam int unsigned CntW = ADDR_W + 1;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SumW = OccW + 2;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic                dec_q, dec_d;
  logic [ADDR_W-1:0]   rd_adr_q, rd_adr_d;
  logic [CntW-1:0]     iss_q, iss_d, acc_q, acc_d;
  logic                p0_vld_q, p1_vld_q;
  logic [ADDR_W-1:0]   p1_adr_q;
  logic [DATA_W-1:0]   fifo_dat_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_adr_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [OccW-1:0]     occ_q, occ_d;
  logic [SumW-1:0]     pending;
  logic                issue, push, pop, flush, room, abort, key_valid;

`ifdef SIMON_KEY_READER_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign flush     = abort && (state_q != StIdle);
  assign key_valid = (occ_q != '0);
  assign pop       = key_valid && key_if.key_ready && !flush;
  assign push      = p1_vld_q;
  assign occ_d     = occ_q + OccW'(push) - OccW'(pop);

  // FIFO entries plus reads still in the memory pipe, after this cycle's pop.
  assign pending = SumW'(occ_q) + SumW'(p0_vld_q) + SumW'(p1_vld_q) - SumW'(pop);
  assign room    = pending < SumW'(FIFO_DEPTH);

  always_comb begin
    state_d  = state_q;
    dec_d    = dec_q;
    rd_adr_d = rd_adr_q;
    iss_d    = iss_q;
    acc_d    = acc_q;
    issue    = 1'b0;
    if (pop) acc_d = acc_q + CntW'(1);
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          dec_d    = decrypt_i;
          rd_adr_d = decrypt_i ? ADDR_W'(ROUNDS - 1) : '0;
          iss_d    = CntW'(1);
          acc_d    = '0;
          issue    = 1'b1;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        if (room && (iss_q < CntW'(ROUNDS))) begin
          issue    = 1'b1;
          iss_d    = iss_q + CntW'(1);
          rd_adr_d = dec_q ? rd_adr_q - ADDR_W'(1) : rd_adr_q + ADDR_W'(1);
          if (iss_d == CntW'(ROUNDS)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (acc_d == CntW'(ROUNDS)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      issue   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      dec_q    <= 1'b0;
      rd_adr_q <= '0;
      iss_q    <= '0;
      acc_q    <= '0;
      p0_vld_q <= 1'b0;
      p1_vld_q <= 1'b0;
      p1_adr_q <= '0;
    end else begin
      state_q  <= state_d;
      dec_q    <= dec_d;
      rd_adr_q <= rd_adr_d;
      iss_q    <= iss_d;
      acc_q    <= acc_d;
      // p0: address presented this cycle; p1: its data is on mem_dat_i this cycle.
      p0_vld_q <= issue;
      p1_vld_q <= p0_vld_q && !flush;
      p1_adr_q <= rd_adr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_dat_q[i] <= '0;
        fifo_adr_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push) begin
        fifo_dat_q[wptr_q] <= mem_dat_i;
        fifo_adr_q[wptr_q] <= p1_adr_q;
        wptr_q             <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      occ_q <= occ_d;
    end
  end

  assign rd_adr_o         = rd_adr_q;
  assign key_if.key_out   = fifo_dat_q[rptr_q];
  assign key_if.round_idx = fifo_adr_q[rptr_q];
  assign key_if.key_valid = key_valid;
  assign busy_o           = (state_q == StFetch) || (state_q == StDrain);
  assign done_o           = (state_q == StDone);
endmodule
